// File: rtl/boreal_filter_scheduler.sv
// boreal_filter_scheduler
// Owns the spatial filter's two entry points: it launches one feature frame at a
// time into an idle filter, and it copies a 16-word staging bank of weights into
// the filter matrix only between frames, so a MAC pass never sees a half-updated
// matrix.
// Optional build feature: define BOREAL_SCHED_WATCHDOG_EN to bound RUN to TIMEOUT
// cycles and raise the sticky wd_err when the filter fails to answer.
module boreal_filter_scheduler #(
    parameter int TIMEOUT = 64,
    parameter int NWORDS  = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_features,
    input  logic         cfg_valid,
    output logic         cfg_ready,
    input  logic [3:0]   cfg_addr,
    input  logic [15:0]  cfg_data,
    input  logic         cfg_commit,
    output logic         commit_pending,
    output logic         load_done,
    output logic         flt_valid,
    output logic [127:0] flt_features,
    output logic [4:0]   flt_host_addr,
    output logic [15:0]  flt_host_din,
    output logic         flt_host_we,
    input  logic         flt_out_valid,
    output logic [15:0]  frame_cnt,
    output logic         wd_err
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_LOAD} state_t;

    // Watchdog counter type; only instantiated in the watchdog build.
    typedef logic [$clog2(TIMEOUT)-1:0] wd_cnt_t;

    localparam logic [3:0] LAST_ADDR = 4'(NWORDS - 1);

    state_t         r_state;
    state_t         w_next;
    logic           r_pending;
    logic [3:0]     r_addr;
    logic [15:0]    r_din;
    logic           r_we;
    logic           r_load_done;
    logic           r_flt_valid;
    logic [127:0]   r_features;
    logic [15:0]    r_frame_cnt;
    logic [15:0]    r_stage [NWORDS];

    logic           w_accept;
    logic           w_cfg_wr;
    logic           w_run_done;
    logic           w_timeout;
    logic           w_load_start;
    logic           w_load_last;
    logic [3:0]     w_addr_nxt;

    // A commit seen this cycle already blocks the frame so LOAD wins the tie;
    // rst_n gating keeps both ready outputs at 0 while reset is held.
    assign in_ready     = rst_n && (r_state == S_IDLE) && !r_pending && !cfg_commit;
    assign cfg_ready    = rst_n && (r_state != S_LOAD);
    assign w_accept     = in_valid && in_ready;
    assign w_cfg_wr     = cfg_valid && cfg_ready;
    assign w_run_done   = (r_state == S_RUN) && flt_out_valid;
    assign w_load_start = (r_state == S_IDLE) && r_pending;
    assign w_load_last  = (r_state == S_LOAD) && (r_addr == LAST_ADDR);
    assign w_addr_nxt   = r_addr + 4'd1;

`ifdef BOREAL_SCHED_WATCHDOG_EN
    wd_cnt_t r_wd_cnt;
    logic    r_wd_err;

    localparam wd_cnt_t WD_LAST = wd_cnt_t'(TIMEOUT - 1);

    assign w_timeout = (r_state == S_RUN) && !flt_out_valid && (r_wd_cnt == WD_LAST);
    assign wd_err    = r_wd_err;

    // Count cycles spent in RUN; an expiry aborts the frame and latches wd_err.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wd_cnt <= '0;
            r_wd_err <= 1'b0;
        end else begin
            r_wd_cnt <= (r_state == S_RUN) ? r_wd_cnt + wd_cnt_t'(1) : '0;
            if (w_timeout) r_wd_err <= 1'b1;
        end
    end
`else
    assign w_timeout = 1'b0;
    assign wd_err    = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        // NOTE: sequential state uses <= so every flop samples pre-edge values.
        else        r_state <= w_next;
    end

    // Next-state decode: pending commit outranks a new frame in IDLE.
    always_comb begin
        // NOTE: default first so no path leaves w_next unassigned (no latch).
        w_next = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (r_pending)     w_next = S_LOAD;
                else if (w_accept) w_next = S_RUN;
            end
            S_RUN:  if (flt_out_valid || w_timeout) w_next = S_IDLE;
            S_LOAD: if (r_addr == LAST_ADDR)        w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Commit request: set by any cfg_commit, consumed when IDLE starts a LOAD.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)            r_pending <= 1'b0;
        else if (cfg_commit)   r_pending <= 1'b1;
        else if (w_load_start) r_pending <= 1'b0;
    end

    // Staging bank; writes are refused during LOAD so the copy reads a stable bank.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: this bank is small and must read as zero after reset, so it is
            // built from reset flops rather than left to a RAM with unknown contents.
            for (int i = 0; i < NWORDS; i++) r_stage[i] <= '0;
        end else if (w_cfg_wr) begin
            r_stage[cfg_addr] <= cfg_data;
        end
    end

    // Filter write port: one word per LOAD cycle, address doubling as the counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr      <= '0;
            r_din       <= '0;
            r_we        <= 1'b0;
            r_load_done <= 1'b0;
        end else begin
            r_load_done <= w_load_last;
            if (w_load_start) begin
                r_addr <= '0;
                r_din  <= r_stage[0];
                r_we   <= 1'b1;
            end else if ((r_state == S_LOAD) && !w_load_last) begin
                r_addr <= w_addr_nxt;
                r_din  <= r_stage[w_addr_nxt];
                r_we   <= 1'b1;
            end else begin
                r_addr <= '0;
                r_din  <= '0;
                r_we   <= 1'b0;
            end
        end
    end

    // Frame launch: capture the accepted frame and pulse flt_valid one cycle later.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_flt_valid <= 1'b0;
            r_features  <= '0;
        end else begin
            r_flt_valid <= w_accept;
            if (w_accept) r_features <= in_features;
        end
    end

    // Completed-frame counter; flt_out_valid outside RUN never counts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)          r_frame_cnt <= '0;
        else if (w_run_done) r_frame_cnt <= r_frame_cnt + 16'd1;
    end

    assign commit_pending = r_pending;
    assign load_done      = r_load_done;
    assign flt_valid      = r_flt_valid;
    assign flt_features   = r_features;
    assign flt_host_addr  = {1'b0, r_addr};
    assign flt_host_din   = r_din;
    assign flt_host_we    = r_we;
    assign frame_cnt      = r_frame_cnt;

endmodule

// File: tb/tb_boreal_filter_scheduler.sv
// Directed bench for boreal_filter_scheduler. Inputs change on the falling edge,
// outputs are sampled on the falling edge (half a cycle after the active edge).
module tb_boreal_filter_scheduler;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_features;
    logic         cfg_valid;
    logic         cfg_ready;
    logic [3:0]   cfg_addr;
    logic [15:0]  cfg_data;
    logic         cfg_commit;
    logic         commit_pending;
    logic         load_done;
    logic         flt_valid;
    logic [127:0] flt_features;
    logic [4:0]   flt_host_addr;
    logic [15:0]  flt_host_din;
    logic         flt_host_we;
    logic         flt_out_valid;
    logic [15:0]  frame_cnt;
    logic         wd_err;

    int checks = 0;
    int errors = 0;
    logic [15:0] exp_cnt = 16'd0;

    localparam logic [127:0] F1 = 128'h0001_0002_0003_0004_0005_0006_0007_0008;
    localparam logic [127:0] F2 = 128'hA5A5_5A5A_FFFF_0000_1234_5678_9ABC_DEF0;
    localparam logic [127:0] F3 = 128'h8000_7FFF_8001_7FFE_0100_00FF_F00F_0FF0;
    localparam logic [127:0] F4 = 128'hDEAD_BEEF_CAFE_F00D_0BAD_C0DE_FACE_B00C;

    boreal_filter_scheduler #(.TIMEOUT(64), .NWORDS(16)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_features    (in_features),
        .cfg_valid      (cfg_valid),
        .cfg_ready      (cfg_ready),
        .cfg_addr       (cfg_addr),
        .cfg_data       (cfg_data),
        .cfg_commit     (cfg_commit),
        .commit_pending (commit_pending),
        .load_done      (load_done),
        .flt_valid      (flt_valid),
        .flt_features   (flt_features),
        .flt_host_addr  (flt_host_addr),
        .flt_host_din   (flt_host_din),
        .flt_host_we    (flt_host_we),
        .flt_out_valid  (flt_out_valid),
        .frame_cnt      (frame_cnt),
        .wd_err         (wd_err)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(negedge clk);
    endtask

    // Bundle of every 1-bit output, all of which must be 0 in reset.
    function automatic logic [7:0] ctl_bits();
        return {in_ready, cfg_ready, commit_pending, load_done,
                flt_valid, flt_host_we, wd_err, 1'b0};
    endfunction

    task automatic test_reset();
        #3;
        checks++;
        if (ctl_bits() !== 8'h00) begin
            errors++; $display("FAIL reset_ctl got %b want 00000000", ctl_bits());
        end
        checks++;
        if ({flt_features, flt_host_addr, flt_host_din, frame_cnt} !== '0) begin
            errors++; $display("FAIL reset_data got %h/%h/%h/%h want 0",
                               flt_features, flt_host_addr, flt_host_din, frame_cnt);
        end
        step();
        rst_n = 1'b1;
        #1;
        checks++;
        if ({in_ready, cfg_ready} !== 2'b11) begin
            errors++; $display("FAIL ready_after_reset got %b want 11", {in_ready, cfg_ready});
        end
    endtask

    task automatic test_load();
        for (int i = 0; i < 16; i++) begin
            cfg_valid = 1'b1; cfg_addr = 4'(i); cfg_data = 16'h0100 + 16'(i);
            step();
        end
        cfg_valid  = 1'b0;
        cfg_commit = 1'b1;
        step();
        cfg_commit = 1'b0;
        checks++;
        if ({commit_pending, in_ready, flt_host_we} !== 3'b100) begin
            errors++; $display("FAIL load_pending got %b want 100",
                               {commit_pending, in_ready, flt_host_we});
        end
        for (int i = 0; i < 16; i++) begin
            step();
            checks++;
            if ({flt_host_we, flt_host_addr, flt_host_din, cfg_ready}
                !== {1'b1, 5'(i), 16'h0100 + 16'(i), 1'b0}) begin
                errors++; $display("FAIL load_word%0d got we=%b a=%h d=%h cr=%b want 1/%h/%h/0",
                                   i, flt_host_we, flt_host_addr, flt_host_din, cfg_ready,
                                   5'(i), 16'h0100 + 16'(i));
            end
        end
        step();
        checks++;
        if ({load_done, flt_host_we, commit_pending, in_ready, flt_host_din} !== {4'b1001, 16'h0}) begin
            errors++; $display("FAIL load_done got ld=%b we=%b cp=%b rdy=%b d=%h want 1/0/0/1/0000",
                               load_done, flt_host_we, commit_pending, in_ready, flt_host_din);
        end
        step();
        checks++;
        if (load_done !== 1'b0) begin
            errors++; $display("FAIL load_done_pulse got %b want 0", load_done);
        end
    endtask

    task automatic test_frame();
        int busy_bad = 0;
        in_valid = 1'b1; in_features = F1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++; $display("FAIL frame_ready got %b want 1", in_ready);
        end
        step();
        in_valid = 1'b0; in_features = '0;
        checks++;
        if ({flt_valid, in_ready} !== 2'b10 || flt_features !== F1) begin
            errors++; $display("FAIL frame_launch got v=%b rdy=%b f=%h want 1/0/%h",
                               flt_valid, in_ready, flt_features, F1);
        end
        // The model filter answers 19 cycles after the launch cycle.
        for (int c = 0; c < 18; c++) begin
            step();
            if (in_ready !== 1'b0 || flt_valid !== 1'b0) busy_bad++;
        end
        checks++;
        if (busy_bad !== 0) begin
            errors++; $display("FAIL frame_busy got %0d bad cycles want 0", busy_bad);
        end
        flt_out_valid = 1'b1;
        step();
        flt_out_valid = 1'b0;
        exp_cnt = exp_cnt + 16'd1;
        checks++;
        if ({frame_cnt, in_ready} !== {exp_cnt, 1'b1} || flt_features !== F1) begin
            errors++; $display("FAIL frame_done got cnt=%h rdy=%b f=%h want %h/1/%h",
                               frame_cnt, in_ready, flt_features, exp_cnt, F1);
        end
        // A stray result outside RUN must not count.
        flt_out_valid = 1'b1;
        step();
        flt_out_valid = 1'b0;
        checks++;
        if (frame_cnt !== exp_cnt) begin
            errors++; $display("FAIL stray_result got %h want %h", frame_cnt, exp_cnt);
        end
    endtask

    task automatic test_commit_and_frame();
        int k = 0;
        int wr = 0;
        int early_launch = 0;
        cfg_commit = 1'b1; in_valid = 1'b1; in_features = F2;
        #1;
        checks++;
        if (in_ready !== 1'b0) begin
            errors++; $display("FAIL tie_ready got %b want 0", in_ready);
        end
        step();
        cfg_commit = 1'b0;
        k = 1;
        while (in_ready !== 1'b1 && k < 40) begin
            if (flt_valid !== 1'b0) early_launch++;
            if (flt_host_we === 1'b1) wr++;
            step();
            k++;
        end
        checks++;
        if (k !== 18 || wr !== 16 || early_launch !== 0) begin
            errors++; $display("FAIL tie_order got k=%0d wr=%0d launch=%0d want 18/16/0",
                               k, wr, early_launch);
        end
        step();
        in_valid = 1'b0; in_features = '0;
        checks++;
        if (flt_valid !== 1'b1 || flt_features !== F2) begin
            errors++; $display("FAIL tie_launch got v=%b f=%h want 1/%h", flt_valid, flt_features, F2);
        end
        repeat (3) step();
        flt_out_valid = 1'b1;
        step();
        flt_out_valid = 1'b0;
        exp_cnt = exp_cnt + 16'd1;
        checks++;
        if (frame_cnt !== exp_cnt) begin
            errors++; $display("FAIL tie_count got %h want %h", frame_cnt, exp_cnt);
        end
    endtask

    task automatic test_commit_during_run();
        int we_in_run = 0;
        int wr = 1;
        int ld = 0;
        in_valid = 1'b1; in_features = F3;
        step();
        in_valid = 1'b0;
        cfg_commit = 1'b1;
        step();
        cfg_commit = 1'b0;
        checks++;
        if ({commit_pending, in_ready} !== 2'b10) begin
            errors++; $display("FAIL run_pending got %b want 10", {commit_pending, in_ready});
        end
        for (int c = 0; c < 5; c++) begin
            step();
            if (flt_host_we !== 1'b0 || in_ready !== 1'b0) we_in_run++;
        end
        checks++;
        if (we_in_run !== 0) begin
            errors++; $display("FAIL run_no_write got %0d bad cycles want 0", we_in_run);
        end
        flt_out_valid = 1'b1;
        step();
        flt_out_valid = 1'b0;
        exp_cnt = exp_cnt + 16'd1;
        checks++;
        if ({commit_pending, flt_host_we, in_ready, frame_cnt} !== {3'b100, exp_cnt}) begin
            errors++; $display("FAIL run_end got cp=%b we=%b rdy=%b cnt=%h want 1/0/0/%h",
                               commit_pending, flt_host_we, in_ready, frame_cnt, exp_cnt);
        end
        step();
        checks++;
        if ({flt_host_we, flt_host_addr, flt_host_din} !== {1'b1, 5'd0, 16'h0100}) begin
            errors++; $display("FAIL run_then_load got we=%b a=%h d=%h want 1/00/0100",
                               flt_host_we, flt_host_addr, flt_host_din);
        end
        for (int c = 0; c < 60 && ld < 2; c++) begin
            cfg_commit = (c == 6);
            step();
            if (flt_host_we === 1'b1) wr++;
            if (load_done === 1'b1) ld++;
        end
        cfg_commit = 1'b0;
        checks++;
        if (wr !== 32 || ld !== 2 || commit_pending !== 1'b0 || in_ready !== 1'b1) begin
            errors++; $display("FAIL double_load got wr=%0d ld=%0d cp=%b rdy=%b want 32/2/0/1",
                               wr, ld, commit_pending, in_ready);
        end
    endtask

    task automatic test_watchdog();
        int n = 1;
        in_valid = 1'b1; in_features = F4;
        step();
        in_valid = 1'b0;
        while (in_ready !== 1'b1 && n < 100) begin
            step();
            n++;
        end
`ifdef BOREAL_SCHED_WATCHDOG_EN
        // RUN spans 64 cycles; the 65th falling edge after acceptance sees IDLE.
        checks++;
        if (n !== 65 || wd_err !== 1'b1 || frame_cnt !== exp_cnt) begin
            errors++; $display("FAIL watchdog got n=%0d wd=%b cnt=%h want 65/1/%h",
                               n, wd_err, frame_cnt, exp_cnt);
        end
        flt_out_valid = 1'b1;
        step();
        flt_out_valid = 1'b0;
        checks++;
        if (frame_cnt !== exp_cnt || wd_err !== 1'b1) begin
            errors++; $display("FAIL late_result got cnt=%h wd=%b want %h/1", frame_cnt, wd_err, exp_cnt);
        end
`else
        checks++;
        if (n !== 100 || in_ready !== 1'b0 || wd_err !== 1'b0) begin
            errors++; $display("FAIL no_watchdog got n=%0d rdy=%b wd=%b want 100/0/0",
                               n, in_ready, wd_err);
        end
        flt_out_valid = 1'b1;
        step();
        flt_out_valid = 1'b0;
        exp_cnt = exp_cnt + 16'd1;
        checks++;
        if (frame_cnt !== exp_cnt || in_ready !== 1'b1) begin
            errors++; $display("FAIL no_watchdog_end got cnt=%h rdy=%b want %h/1",
                               frame_cnt, in_ready, exp_cnt);
        end
`endif
    endtask

    task automatic test_reset_mid_load();
        int stray = 0;
        cfg_commit = 1'b1;
        step();
        cfg_commit = 1'b0;
        step();
        cfg_commit = 1'b1;
        step();
        cfg_commit = 1'b0;
        checks++;
        if ({flt_host_we, commit_pending, flt_host_addr} !== {2'b11, 5'd1}) begin
            errors++; $display("FAIL mid_load_setup got we=%b cp=%b a=%h want 1/1/01",
                               flt_host_we, commit_pending, flt_host_addr);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (ctl_bits() !== 8'h00 ||
            {flt_features, flt_host_addr, flt_host_din, frame_cnt} !== '0) begin
            errors++; $display("FAIL async_reset got ctl=%b f=%h a=%h d=%h cnt=%h want 0",
                               ctl_bits(), flt_features, flt_host_addr, flt_host_din, frame_cnt);
        end
        step();
        rst_n = 1'b1;
        exp_cnt = 16'd0;
        for (int c = 0; c < 20; c++) begin
            step();
            if (flt_host_we !== 1'b0 || commit_pending !== 1'b0 || in_ready !== 1'b1) stray++;
        end
        checks++;
        if (stray !== 0) begin
            errors++; $display("FAIL pending_cleared got %0d bad cycles want 0", stray);
        end
    endtask

    task automatic test_wrap();
        force dut.r_frame_cnt = 16'hFFFF;
        step();
        release dut.r_frame_cnt;
        step();
        checks++;
        if (frame_cnt !== 16'hFFFF) begin
            errors++; $display("FAIL wrap_preload got %h want ffff", frame_cnt);
        end
        in_valid = 1'b1; in_features = F1;
        step();
        in_valid = 1'b0;
        step();
        flt_out_valid = 1'b1;
        step();
        flt_out_valid = 1'b0;
        checks++;
        if (frame_cnt !== 16'h0000) begin
            errors++; $display("FAIL wrap got %h want 0000", frame_cnt);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL tb_timeout simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        in_valid = 1'b0; in_features = '0;
        cfg_valid = 1'b0; cfg_addr = '0; cfg_data = '0; cfg_commit = 1'b0;
        flt_out_valid = 1'b0;
        test_reset();
        test_load();
        test_frame();
        test_commit_and_frame();
        test_commit_during_run();
        test_watchdog();
        test_reset_mid_load();
        test_wrap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
